// File: rtl/microwave_cook_ctrl.sv
// Cook-cycle controller: keypad entry of a BCD mm:ss time, countdown driven by
// divider ticks, pause on door/stop, and a timed beeper once cooking completes.
module microwave_cook_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  output logic [15:0] time_bcd,
  output logic        magnetron_on,
  output logic        beep,
  output logic        done,
  output logic [2:0]  state
);

  localparam int BEEP_TICKS = BEEP_SECS * TICKS_PER_SEC;
  localparam int SUB_W      = $clog2(TICKS_PER_SEC);
  localparam int BEEP_W     = $clog2(BEEP_TICKS);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [15:0]       time_reg, time_next;
  logic [SUB_W-1:0]  sub_reg, sub_next;
  logic [BEEP_W-1:0] beep_cnt_reg, beep_cnt_next;
  logic              mag_reg, mag_next;
  logic              beep_reg, beep_next;
  logic              done_reg, done_next;
  logic              key_ok;
  logic [15:0]       time_dec;

  assign key_ok = key_valid && (key_digit <= 4'd9);

  // One-second countdown; the seconds-tens digit borrows to 5 so 1:00 -> 0:59,
  // while entered values such as 0090 still step down digit-wise.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign time_dec = bcd_dec(time_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      time_reg     <= '0;
      sub_reg      <= '0;
      beep_cnt_reg <= '0;
      mag_reg      <= 1'b0;
      beep_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      time_reg     <= time_next;
      sub_reg      <= sub_next;
      beep_cnt_reg <= beep_cnt_next;
      mag_reg      <= mag_next;
      beep_reg     <= beep_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    time_next     = time_reg;
    sub_next      = sub_reg;
    beep_cnt_next = beep_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (key_ok) begin
          time_next  = {time_reg[11:0], key_digit};
          state_next = S_SET;
        end
      end
      S_SET: begin
        if (stop) begin
          time_next  = '0;
          state_next = S_IDLE;
        end else if (start) begin
          if (!door_open && time_reg != 16'd0) begin
            sub_next   = '0;
            state_next = S_COOK;
          end
        end else if (key_ok) begin
          time_next = {time_reg[11:0], key_digit};
        end
      end
      S_COOK: begin
        if (stop || door_open) begin
          state_next = S_PAUSE;
        end else if (tick) begin
          if (sub_reg == SUB_LAST) begin
            sub_next  = '0;
            time_next = time_dec;
            if (time_dec == 16'd0) begin
              beep_cnt_next = '0;
              state_next    = S_DONE;
            end
          end else begin
            sub_next = sub_reg + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          time_next  = '0;
          sub_next   = '0;
          state_next = S_IDLE;
        end else if (start && !door_open) begin
          state_next = S_COOK;
        end
      end
      S_DONE: begin
        time_next = '0;
        if (stop || start || key_valid || door_open) begin
          beep_cnt_next = '0;
          state_next    = S_IDLE;
        end else if (tick) begin
          if (beep_cnt_reg == BEEP_LAST) begin
            beep_cnt_next = '0;
            state_next    = S_IDLE;
          end else begin
            beep_cnt_next = beep_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next    = S_IDLE;
        time_next     = '0;
        sub_next      = '0;
        beep_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    mag_next  = (state_next == S_COOK);
    beep_next = (state_next == S_DONE);
    done_next = (state_reg == S_COOK) && (state_next == S_DONE);
  end

  assign state        = state_reg;
  assign time_bcd     = time_reg;
  assign magnetron_on = mag_reg;
  assign beep         = beep_reg;
  assign done         = done_reg;

endmodule
